// File: rtl/wifi_rx_top_deinterleaver48.sv
// Receive-side block deinterleaver, BPSK rate (NCBPS=48, NBPSC=1).
// Two 48-entry banks ping-pong: one fills in received order while the other drains in coded order.
module wifi_rx_top_deinterleaver48 #(
  parameter int NCBPS  = 48,
  parameter int NBPSC  = 1,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              sym_last,
  output logic              overflow,
  output logic              finished,
  output logic              dbg_state
);

  if (NCBPS != 48 || NBPSC != 1) begin : g_unsupported_config
    $error("wifi_rx_top_deinterleaver48 supports only NCBPS=48, NBPSC=1");
  end

  localparam logic [5:0] LAST_IDX = 6'(NCBPS - 1);
  localparam int         DEPTH    = 2 * NCBPS;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rd_state_t;

  // Handshake: a sample transfers on a cycle where valid_in && ready_in;
  // valid_in while ready_in=0 drops the sample and latches overflow.
  // Output side has no backpressure: data_out/sym_last are valid when valid_out=1.

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  logic [1:0]        full_q, full_d;
  logic [5:0]        wr_idx_q;
  logic              wr_bank_q;
  logic              overflow_q;

  rd_state_t         state_q;
  logic [5:0]        rd_k_q;
  logic              rd_bank_q;
  logic              valid_out_q;
  logic [DATA_W-1:0] data_out_q;
  logic              sym_last_q;
  logic              finished_q;

  logic              wr_accept;
  logic              wr_done;
  logic              rd_issue;
  logic              rd_release;
  logic [5:0]        rd_row;
  logic [5:0]        rd_addr;
  logic [6:0]        wr_mem_addr;
  logic [6:0]        rd_mem_addr;

  always_comb begin
    rd_issue   = (state_q == ST_RUN) && enable;
    rd_release = rd_issue && (rd_k_q == LAST_IDX);
    // A bank being released this edge may take its first new sample on the same edge;
    // the last read (address 47) never collides with the first write (address 0).
    ready_in   = !full_q[wr_bank_q] || (rd_release && (rd_bank_q == wr_bank_q));
    wr_accept  = valid_in && ready_in;
    wr_done    = wr_accept && (wr_idx_q == LAST_IDX);
    full_d     = full_q;
    if (rd_release) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (wr_done) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  // Coded-order read address: a(k) = 3*(k mod 16) + (k >> 4)
  always_comb begin
    rd_row      = {2'b00, rd_k_q[3:0]};
    rd_addr     = (rd_row << 1) + rd_row + {4'b0000, rd_k_q[5:4]};
    wr_mem_addr = wr_bank_q ? (7'(wr_idx_q) + 7'(NCBPS)) : 7'(wr_idx_q);
    rd_mem_addr = rd_bank_q ? (7'(rd_addr) + 7'(NCBPS)) : 7'(rd_addr);
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_mem_addr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q     <= 2'b00;
      wr_idx_q   <= 6'd0;
      wr_bank_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      full_q <= full_d;
      if (wr_accept) begin
        if (wr_done) begin
          wr_idx_q  <= 6'd0;
          wr_bank_q <= !wr_bank_q;
        end else begin
          wr_idx_q <= wr_idx_q + 6'd1;
        end
      end
      if (valid_in && !ready_in) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_k_q      <= 6'd0;
      rd_bank_q   <= 1'b0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      sym_last_q  <= 1'b0;
      finished_q  <= 1'b1;
    end else begin
      valid_out_q <= rd_issue;
      sym_last_q  <= rd_release;
      if (rd_issue) begin
        data_out_q <= mem_q[rd_mem_addr];
      end
      finished_q <= (full_q == 2'b00) && (wr_idx_q == 6'd0) &&
                    (state_q == ST_IDLE) && !valid_out_q;
      case (state_q)
        ST_IDLE: begin
          if (full_q[rd_bank_q]) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (rd_issue) begin
            if (rd_release) begin
              rd_k_q    <= 6'd0;
              rd_bank_q <= !rd_bank_q;
              // Stay in RUN with no gap if the other bank is already waiting
              if (!full_q[!rd_bank_q]) begin
                state_q <= ST_IDLE;
              end
            end else begin
              rd_k_q <= rd_k_q + 6'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign sym_last  = sym_last_q;
  assign overflow  = overflow_q;
  assign finished  = finished_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wifi_rx_top_deinterleaver48.sv
// Directed bench for wifi_rx_top_deinterleaver48 with 6-bit samples.
module tb_wifi_rx_top_deinterleaver48;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         valid_in;
  logic [W-1:0] data_in;
  logic         ready_in;
  logic         valid_out;
  logic [W-1:0] data_out;
  logic         sym_last;
  logic         overflow;
  logic         finished;
  logic         dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int accept_cyc;
  int ready_low;

  logic [W-1:0] out_q[$];
  logic         last_q[$];
  int           cyc_q[$];
  logic [W-1:0] exp_q[$];

  wifi_rx_top_deinterleaver48 #(.NCBPS(48), .NBPSC(1), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out), .sym_last(sym_last),
    .overflow(overflow), .finished(finished), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // output collector
  always @(negedge clk) begin
    if (valid_out) begin
      out_q.push_back(data_out);
      last_q.push_back(sym_last);
      cyc_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_checks);
    $fatal(1);
  end

  // drivers
  task automatic apply_reset();
    reset = 1'b1; valid_in = 1'b0; enable = 1'b1; data_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic clear_mon();
    out_q.delete(); last_q.delete(); cyc_q.delete(); exp_q.delete();
  endtask

  task automatic send_sample(input logic [W-1:0] d);
    valid_in = 1'b1;
    data_in  = d;
    if (!ready_in) ready_low++;
    @(posedge clk); #1;
    accept_cyc = cyc;
    valid_in = 1'b0;
  endtask

  // expected coded order: 0,3,..,45, 1,4,..,46, 2,5,..,47
  task automatic push_expected(input logic [W-1:0] sym [48]);
    for (int g = 0; g < 3; g++)
      for (int m = 0; m < 16; m++)
        exp_q.push_back(sym[3*m + g]);
  endtask

  task automatic wait_outputs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_q.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (out_q.size() >= n) ok = 1'b1;
  endtask

  task automatic wait_finished(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (finished === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  // scoreboard compare of out_q against exp_q; returns mismatch count
  task automatic compare_data(output int errs, output int first_bad);
    errs = 0; first_bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
    end
    if (out_q.size() != exp_q.size()) errs++;
  endtask

  // tests
  task automatic test_reset();
    n_checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid_out: got %b expected 0", valid_out); else n_pass++;
    n_checks++; if (data_out !== '0) $display("FAIL reset_data_out: got %0d expected 0", data_out); else n_pass++;
    n_checks++; if (sym_last !== 1'b0) $display("FAIL reset_sym_last: got %b expected 0", sym_last); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
    n_checks++; if (ready_in !== 1'b1) $display("FAIL reset_ready_in: got %b expected 1", ready_in); else n_pass++;
    n_checks++; if (finished !== 1'b1) $display("FAIL reset_finished: got %b expected 1", finished); else n_pass++;
    n_checks++; if (dbg_state !== 1'b0) $display("FAIL reset_state: got %b expected 0 (idle)", dbg_state); else n_pass++;
  endtask

  task automatic test_onehot(input int hot, input int exp_k);
    bit ok;
    int pos, ones, lasts, acc;
    clear_mon();
    for (int j = 0; j < 48; j++) send_sample((j == hot) ? 6'd1 : 6'd0);
    acc = accept_cyc;
    wait_outputs(48, 200, ok);
    n_checks++; if (!ok) $display("FAIL onehot%0d_timeout: got %0d outputs expected 48", hot, out_q.size()); else n_pass++;
    pos = -1; ones = 0; lasts = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      if (out_q[i] !== 6'd0) begin ones++; pos = i; end
      if (last_q[i] === 1'b1) lasts++;
    end
    n_checks++; if (pos != exp_k) $display("FAIL onehot%0d_position: got k=%0d expected k=%0d", hot, pos, exp_k); else n_pass++;
    n_checks++; if (ones != 1) $display("FAIL onehot%0d_ones: got %0d expected 1", hot, ones); else n_pass++;
    n_checks++;
    if (lasts != 1 || out_q.size() < 48 || last_q[47] !== 1'b1)
      $display("FAIL onehot%0d_sym_last: got %0d markers expected 1 at k=47", hot, lasts);
    else n_pass++;
    n_checks++;
    if (cyc_q.size() == 0 || cyc_q[0] - acc != 2)
      $display("FAIL onehot%0d_latency: got %0d cycles expected 2", hot, (cyc_q.size() == 0) ? -1 : cyc_q[0] - acc);
    else n_pass++;
    wait_finished(10, ok);
    n_checks++; if (!ok) $display("FAIL onehot%0d_finished: got %b expected 1", hot, finished); else n_pass++;
  endtask

  task automatic test_permutation();
    bit ok;
    logic [W-1:0] sym [48];
    clear_mon();
    for (int j = 0; j < 48; j++) sym[j] = 6'(j);
    push_expected(sym);
    for (int j = 0; j < 48; j++) send_sample(sym[j]);
    wait_outputs(48, 200, ok);
    n_checks++; if (!ok) $display("FAIL perm_timeout: got %0d outputs expected 48", out_q.size()); else n_pass++;
    for (int k = 0; k < 48; k++) begin
      n_checks++;
      if (k >= out_q.size()) $display("FAIL perm_k%0d: got none expected %0d", k, exp_q[k]);
      else if (out_q[k] !== exp_q[k]) $display("FAIL perm_k%0d: got %0d expected %0d", k, out_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int errs, first_bad, gaps, bad_last;
    logic [W-1:0] sym [48];
    clear_mon();
    ready_low = 0;
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 48; j++) sym[j] = 6'($urandom_range(0, 63));
      push_expected(sym);
      for (int j = 0; j < 48; j++) send_sample(sym[j]);
    end
    wait_outputs(192, 400, ok);
    n_checks++; if (!ok) $display("FAIL b2b_timeout: got %0d outputs expected 192", out_q.size()); else n_pass++;
    compare_data(errs, first_bad);
    n_checks++; if (errs != 0) $display("FAIL b2b_data: got %0d errors (first k=%0d) expected 0", errs, first_bad); else n_pass++;
    gaps = 0; bad_last = 0;
    for (int i = 0; i + 1 < cyc_q.size(); i++) if (cyc_q[i+1] != cyc_q[i] + 1) gaps++;
    for (int i = 0; i < last_q.size(); i++) if (last_q[i] !== ((i % 48) == 47)) bad_last++;
    n_checks++; if (gaps != 0) $display("FAIL b2b_gapless: got %0d gaps expected 0", gaps); else n_pass++;
    n_checks++; if (bad_last != 0) $display("FAIL b2b_sym_last: got %0d bad markers expected 0", bad_last); else n_pass++;
    n_checks++; if (ready_low != 0) $display("FAIL b2b_ready_in: got %0d low cycles expected 0", ready_low); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL b2b_overflow: got %b expected 0", overflow); else n_pass++;
    wait_finished(10, ok);
    n_checks++; if (!ok) $display("FAIL b2b_finished: got %b expected 1", finished); else n_pass++;
  endtask

  task automatic test_stall_overflow();
    bit ok;
    int errs, first_bad;
    logic [W-1:0] sym [48];
    logic [W-1:0] all [96];
    clear_mon();
    enable = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < 48; j++) begin
        sym[j] = 6'($urandom_range(0, 63));
        all[48*s + j] = sym[j];
      end
      push_expected(sym);
    end
    for (int i = 0; i < 96; i++) begin
      send_sample(all[i]);
      if (i == 94) begin
        n_checks++; if (ready_in !== 1'b1) $display("FAIL stall_ready_95: got %b expected 1", ready_in); else n_pass++;
      end
    end
    n_checks++; if (ready_in !== 1'b0) $display("FAIL stall_ready_96: got %b expected 0", ready_in); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL stall_overflow_pre: got %b expected 0", overflow); else n_pass++;
    send_sample(6'h3F);
    n_checks++; if (overflow !== 1'b1) $display("FAIL stall_overflow_set: got %b expected 1", overflow); else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (out_q.size() != 0) $display("FAIL stall_no_output: got %0d outputs expected 0", out_q.size()); else n_pass++;
    enable = 1'b1;
    wait_outputs(96, 300, ok);
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (out_q.size() != 96) $display("FAIL stall_count: got %0d outputs expected 96", out_q.size()); else n_pass++;
    compare_data(errs, first_bad);
    n_checks++; if (errs != 0) $display("FAIL stall_data: got %0d errors (first k=%0d) expected 0", errs, first_bad); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL stall_overflow_sticky: got %b expected 1", overflow); else n_pass++;
    apply_reset();
    n_checks++; if (overflow !== 1'b0) $display("FAIL stall_overflow_cleared: got %b expected 0", overflow); else n_pass++;
  endtask

  task automatic test_stall_mid();
    bit ok;
    int errs, first_bad, bad_gap;
    logic [W-1:0] sym [48];
    clear_mon();
    for (int j = 0; j < 48; j++) sym[j] = 6'($urandom_range(0, 63));
    push_expected(sym);
    fork
      begin
        for (int j = 0; j < 48; j++) send_sample(sym[j]);
      end
      begin
        for (int g = 0; g < 400 && out_q.size() < 48; g++) begin
          @(posedge clk); #1;
          enable = ~enable;
        end
        enable = 1'b1;
      end
    join
    wait_outputs(48, 200, ok);
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (out_q.size() != 48) $display("FAIL midstall_count: got %0d outputs expected 48", out_q.size()); else n_pass++;
    compare_data(errs, first_bad);
    n_checks++; if (errs != 0) $display("FAIL midstall_data: got %0d errors (first k=%0d) expected 0", errs, first_bad); else n_pass++;
    bad_gap = 0;
    for (int i = 0; i + 1 < cyc_q.size(); i++) if (cyc_q[i+1] - cyc_q[i] != 2) bad_gap++;
    n_checks++; if (bad_gap != 0) $display("FAIL midstall_spacing: got %0d irregular gaps expected 0", bad_gap); else n_pass++;
  endtask

  task automatic test_partial();
    clear_mon();
    for (int j = 0; j < 10; j++) send_sample(6'(j + 1));
    repeat (60) @(posedge clk);
    #1;
    n_checks++; if (out_q.size() != 0) $display("FAIL partial_no_output: got %0d outputs expected 0", out_q.size()); else n_pass++;
    n_checks++; if (finished !== 1'b0) $display("FAIL partial_finished: got %b expected 0", finished); else n_pass++;
    apply_reset();
    n_checks++; if (finished !== 1'b1) $display("FAIL partial_reset_finished: got %b expected 1", finished); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int errs, first_bad;
    logic [W-1:0] sym [48];
    clear_mon();
    for (int j = 0; j < 48; j++) sym[j] = 6'($urandom_range(0, 63));
    push_expected(sym);
    for (int j = 0; j < 48; j++) send_sample(sym[j]);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (out_q.size() >= 21) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) $display("FAIL rstmid_reach_k20: got %0d outputs expected 21", out_q.size()); else n_pass++;
    n_checks++;
    if (out_q.size() < 21 || out_q[20] !== exp_q[20]) $display("FAIL rstmid_k20_data: got %0d expected %0d", (out_q.size() < 21) ? 0 : out_q[20], exp_q[20]);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (valid_out !== 1'b0) $display("FAIL rstmid_valid_out: got %b expected 0", valid_out); else n_pass++;
    n_checks++; if (finished !== 1'b1) $display("FAIL rstmid_finished: got %b expected 1", finished); else n_pass++;
    n_checks++; if (ready_in !== 1'b1) $display("FAIL rstmid_ready_in: got %b expected 1", ready_in); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_mon();
    for (int j = 0; j < 48; j++) sym[j] = 6'($urandom_range(0, 63));
    push_expected(sym);
    for (int j = 0; j < 48; j++) send_sample(sym[j]);
    wait_outputs(48, 200, ok);
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (out_q.size() != 48) $display("FAIL rstmid_fresh_count: got %0d outputs expected 48", out_q.size()); else n_pass++;
    compare_data(errs, first_bad);
    n_checks++; if (errs != 0) $display("FAIL rstmid_fresh_data: got %0d errors (first k=%0d) expected 0", errs, first_bad); else n_pass++;
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_onehot(1, 16);
    test_onehot(3, 1);
    test_onehot(47, 47);
    test_onehot(0, 0);
    test_permutation();
    test_back_to_back();
    test_stall_overflow();
    test_stall_mid();
    test_partial();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wifi_rx_top_deinterleaver48.md
Name: wifi_rx_top_deinterleaver48

Overview:
Receive-side block deinterleaver for the WIFI PHY, BPSK rate, with NCBPS=48 and NBPSC=1. It sits after the demapper and before the depuncturer/Viterbi. It accepts bit-serial (optionally soft) coded bits in received order and emits them in original coded order, one 48-bit OFDM symbol at a time. Two 48-entry banks are used ping-pong, so input streaming continues while the previous symbol is read out.

Parameters:
NCBPS, 48, coded bits per symbol; also the bank depth. Only the value 48 is supported.
NBPSC, 1, bits per subcarrier. Only 1 is supported, so the second permutation is identity.
DATA_W, 1, width of each input/output sample (greater than 1 for soft decisions).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  output advance enable; 0 stalls the read side.
valid_in  input  1  data_in carries a received sample this cycle.
data_in  input  DATA_W  received sample, in received (interleaved) order.
ready_in  output  1  block can accept a sample this cycle.
valid_out  output  1  data_out valid.
data_out  output  DATA_W  deinterleaved sample.
sym_last  output  1  marks the 48th output of a symbol; qualified by valid_out.
overflow  output  1  sticky: a sample was offered while ready_in=0.
finished  output  1  block idle: both banks empty, no partial symbol, pipeline drained.

Behaviour:
- Reset (asynchronous, active-high) values:
  - valid_out=0, data_out=0, sym_last=0, overflow=0, ready_in=1, finished=1.
  - Write/read counters=0, both banks empty, write bank=0, read bank=0.
  - Bank contents are not reset.
- Write side:
  - A sample is accepted when valid_in && ready_in. It is stored at bank[wr_bank][wr_idx] with sequential address j = 0..47.
  - When the sample with j=47 is accepted: that bank is marked full, wr_idx wraps to 0, and wr_bank toggles.
- ready_in = !(bank[wr_bank] full). It is deasserted only when both banks are full.
- Overflow: valid_in=1 with ready_in=0 drops the sample, sets overflow (sticky until reset), and leaves counters unchanged.
- Read-side FSM has two states.
  - IDLE -> RUN when bank[rd_bank] is full.
  - RUN: on each cycle with enable=1, issue read index k (0..47) at address a(k) = 3*(k mod 16) + (k >> 4), then increment k.
  - When k=47 is issued: bank[rd_bank] is released (empty), rd_bank toggles, and k returns to 0. The FSM goes back to IDLE unless the other bank is already full; in that case it stays in RUN with no gap cycle.
  - enable=0 holds k and the state, and no issue occurs.
- Output register (read latency 1):
  - valid_out is 1 the cycle after an issue, otherwise 0.
  - data_out is registered and holds its last value when valid_out=0.
  - sym_last is 1 with valid_out for the k=47 issue.
- Latency: the first valid_out of a symbol is 2 cycles after the clock edge that accepted its j=47 sample, given enable=1 and the FSM in IDLE.
- Full-rate throughput: with continuous input and enable=1, output is gapless and no overflow occurs.
- Simultaneous write-complete and read-release on the same edge:
  - The release is applied first. ready_in stays 1 and the new full flag is set in the same cycle.
  - A full flag set and cleared on the same edge for the same bank cannot occur, since the write bank never equals a bank being read while full.
- Partial symbol (fewer than 48 accepted samples): retained and never output. finished stays 0 while wr_idx≠0.
- finished = banks empty && wr_idx==0 && FSM IDLE && valid_out==0. It is a registered output, updated one cycle after the condition becomes true.
- reset asserted mid-operation: the block returns to reset values immediately and the in-flight symbol is discarded.

Test Plan:
- One-hot symbols, enable=1, each sent as 48 samples (only the stated sample 1, rest 0):
  - sample j=1 → the single 1 appears at output k=16 (17th valid_out); valid_out first rises 2 cycles after the j=47 accept edge; sym_last on the 48th output.
  - j=3 → k=1.
  - j=47 → k=47.
  - j=0 → k=0.
- Exhaustive permutation: send data_in = j (DATA_W=6) for j=0..47 → data_out sequence is 0,3,6,…,45,1,4,…,46,2,5,…,47.
- Back-to-back traffic: 4 continuous symbols, enable=1 → 192 gapless outputs, ready_in never 0, overflow=0, and finished returns to 1 after the last output.
- Stall and overflow: hold enable=0 while sending 2 symbols → ready_in drops after the 96th accept; a 97th offered sample sets overflow=1 and is dropped. Then enable=1 → exactly 96 correct outputs.
- Stall mid-symbol: toggle enable every other cycle during readout → output order is unchanged, valid_out tracks enable with 1-cycle delay, and no duplicated or missing samples.
- Reset mid-readout: assert reset at output k=20 → on the same cycle valid_out=0, finished=1, ready_in=1. A fresh symbol sent afterwards deinterleaves correctly.
